// File: rtl/axis_block_assembler.sv
// AXI4-Stream to wide-block assembler for the SHA3 absorb path.
// Packs TKEEP-masked beats little-endian into one block per handshake.
module axis_block_assembler #(
  parameter int DATA_W  = 16,
  parameter int BLOCK_W = 128
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [DATA_W-1:0]                TDATA,
  input  logic [DATA_W/8-1:0]              TKEEP,
  input  logic                             TVALID,
  input  logic                             TLAST,
  output logic                             TREADY,
  output logic [BLOCK_W-1:0]               block_data,
  output logic [$clog2(BLOCK_W/8+1)-1:0]   block_bytes,
  output logic                             block_last,
  output logic                             block_valid,
  input  logic                             block_ready,
  output logic                             keep_err
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int BEATS  = BLOCK_W / DATA_W;
  localparam int CNT_W  = $clog2(BLOCK_W / 8 + 1);
  localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]        state;
  logic [BC_W-1:0]   beat;
  logic [DATA_W-1:0] masked;
  logic [CNT_W-1:0]  pop;
  logic [KEEP_W:0]   keep_ext;
  logic [KEEP_W:0]   keep_inc;
  logic              keep_bad;
  logic              accept;
  logic              last_beat;

  always_comb begin
    masked = '0;
    pop    = '0;
    for (int k = 0; k < KEEP_W; k++) begin
      if (TKEEP[k]) begin
        masked[8*k +: 8] = TDATA[8*k +: 8];
        pop = pop + CNT_W'(1);
      end
    end
  end

  // LSB-contiguous masks are exactly those where mask & (mask+1) == 0
  always_comb begin
    keep_ext = {1'b0, TKEEP};
    keep_inc = keep_ext + (KEEP_W+1)'(1);
    keep_bad = (TKEEP == '0)
            || ((keep_ext & keep_inc) != '0)
            || (!TLAST && !(&TKEEP));
  end

  assign accept    = TVALID && TREADY;
  assign last_beat = (beat == BC_W'(BEATS - 1));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= FILL;
      beat        <= '0;
      TREADY      <= 1'b0;
      block_data  <= '0;
      block_bytes <= '0;
      block_last  <= 1'b0;
      block_valid <= 1'b0;
      keep_err    <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          TREADY <= 1'b1;
          if (accept) begin
            block_data[int'(beat)*DATA_W +: DATA_W] <= masked;
            block_bytes <= block_bytes + pop;
            if (keep_bad) keep_err <= 1'b1;
            if (TLAST || last_beat) begin
              state       <= HOLD;
              TREADY      <= 1'b0;
              block_valid <= 1'b1;
              block_last  <= TLAST;
            end else begin
              beat <= beat + BC_W'(1);
            end
          end
        end
        HOLD: begin
          if (block_ready) begin
            state       <= FILL;
            beat        <= '0;
            TREADY      <= 1'b1;
            block_data  <= '0;
            block_bytes <= '0;
            block_last  <= 1'b0;
            block_valid <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
